// File: rtl/hazard_stall_controller.sv
// Hazard detection and pipeline sequencing: load-use stall, taken-branch/jump
// flush, structural stall on a multi-cycle mult/div unit, plus a saturating
// stall-cycle performance counter.
module hazard_stall_controller #(
   parameter int unsigned MDU_LATENCY = 4,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             MemRead_ID_EX,
   input  logic [4:0]       rt_ID_EX,
   input  logic [4:0]       rs_IF_ID,
   input  logic [4:0]       rt_IF_ID,
   input  logic             uses_rt_IF_ID,
   input  logic             mdu_start_ID,
   input  logic             hilo_read_ID,
   input  logic             jump_ID,
   input  logic             branch_taken_EX,
   output logic             PCWrite,
   output logic             IF_ID_Write,
   output logic             IF_ID_Flush,
   output logic             ID_EX_Bubble,
   output logic             mdu_busy,
   output logic             mdu_done,
   output logic [CNT_W-1:0] stall_cycles
);

   typedef enum logic {IDLE, RUN} mdu_state_t;

   mdu_state_t state;
   logic [3:0] cnt;
   logic       load_use;
   logic       mdu_stall;
   logic       stall;
   logic       accept;

   // Hazard terms and the "ID advances" condition
   always_comb begin
      load_use  = MemRead_ID_EX && (rt_ID_EX != 5'd0) &&
                  ((rt_ID_EX == rs_IF_ID) || (uses_rt_IF_ID && (rt_ID_EX == rt_IF_ID)));
      mdu_stall = mdu_busy && (mdu_start_ID || hilo_read_ID);
      stall     = load_use || mdu_stall;
      accept    = !branch_taken_EX && !stall;
   end

   // Prioritised pipeline control; reset holds the front end frozen and flushed
   always_comb begin
      PCWrite      = 1'b1;
      IF_ID_Write  = 1'b1;
      IF_ID_Flush  = 1'b0;
      ID_EX_Bubble = 1'b0;
      if (!rst_n) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (branch_taken_EX) begin
         IF_ID_Flush  = 1'b1;
         ID_EX_Bubble = 1'b1;
      end else if (stall) begin
         PCWrite      = 1'b0;
         IF_ID_Write  = 1'b0;
         ID_EX_Bubble = 1'b1;
      end else if (jump_ID) begin
         IF_ID_Flush  = 1'b1;
      end
   end

   // MDU occupancy FSM, done pulse and saturating stall counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         mdu_busy     <= 1'b0;
         mdu_done     <= 1'b0;
         stall_cycles <= '0;
      end else begin
         mdu_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept && mdu_start_ID) begin
                  state    <= RUN;
                  cnt      <= 4'(MDU_LATENCY - 1);
                  mdu_busy <= 1'b1;
               end
            end
            RUN: begin
               // A taken branch in EX is younger than the running op, so RUN never aborts here
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  state    <= IDLE;
                  mdu_busy <= 1'b0;
                  mdu_done <= 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               mdu_busy <= 1'b0;
            end
         endcase
         if (stall && !branch_taken_EX && (stall_cycles != '1))
            stall_cycles <= stall_cycles + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller: a driver applies directed and
// random stimulus and queues the reference model's expectation; a monitor pops
// and compares every cycle.
module tb_hazard_stall_controller;

   localparam int unsigned LAT   = 4;
   localparam int unsigned CW    = 4;
   localparam int unsigned CMAX  = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          MemRead_ID_EX;
   logic [4:0]    rt_ID_EX, rs_IF_ID, rt_IF_ID;
   logic          uses_rt_IF_ID, mdu_start_ID, hilo_read_ID, jump_ID, branch_taken_EX;
   logic          PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, mdu_busy, mdu_done;
   logic [CW-1:0] stall_cycles;

   hazard_stall_controller #(.MDU_LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .MemRead_ID_EX(MemRead_ID_EX), .rt_ID_EX(rt_ID_EX),
      .rs_IF_ID(rs_IF_ID), .rt_IF_ID(rt_IF_ID), .uses_rt_IF_ID(uses_rt_IF_ID),
      .mdu_start_ID(mdu_start_ID), .hilo_read_ID(hilo_read_ID), .jump_ID(jump_ID),
      .branch_taken_EX(branch_taken_EX),
      .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
      .ID_EX_Bubble(ID_EX_Bubble), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
      .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          pc, ifw, fl, bub, busy, done;
      logic [CW-1:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;

   // reference model state
   int   busy_left = 0;
   bit   done_m    = 0;
   int   scnt      = 0;

   task automatic step(input bit rst, input bit mr, input int rte, input int rsi,
                       input int rti, input bit urt, input bit ms, input bit hl,
                       input bit jp, input bit br);
      exp_t e;
      bit   lu, mst, st;
      @(negedge clk);
      rst_n = rst; MemRead_ID_EX = mr; rt_ID_EX = 5'(rte); rs_IF_ID = 5'(rsi);
      rt_IF_ID = 5'(rti); uses_rt_IF_ID = urt; mdu_start_ID = ms;
      hilo_read_ID = hl; jump_ID = jp; branch_taken_EX = br;
      if (!rst) begin
         busy_left = 0; done_m = 0; scnt = 0;
      end
      lu  = mr && rte != 0 && (rte == rsi || (urt && rte == rti));
      mst = (busy_left > 0) && (ms || hl);
      st  = lu || mst;
      if (!rst)     {e.pc, e.ifw, e.fl, e.bub} = 4'b0011;
      else if (br)  {e.pc, e.ifw, e.fl, e.bub} = 4'b1111;
      else if (st)  {e.pc, e.ifw, e.fl, e.bub} = 4'b0001;
      else if (jp)  {e.pc, e.ifw, e.fl, e.bub} = 4'b1110;
      else          {e.pc, e.ifw, e.fl, e.bub} = 4'b1100;
      e.busy = busy_left > 0;
      e.done = done_m;
      e.sc   = CW'(scnt);
      exp_q.push_back(e);
      if (rst) begin
         done_m = (busy_left == 1);
         if (busy_left > 0)            busy_left--;
         else if (!br && !st && ms)    busy_left = LAT;
         if (st && !br && scnt < CMAX) scnt++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // monitor: compare each queued expectation in the same cycle it was issued
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (PCWrite !== e.pc) begin miscompares++;
               $display("FAIL PCWrite vec %0d got %b exp %b", vectors, PCWrite, e.pc); end
            if (IF_ID_Write !== e.ifw) begin miscompares++;
               $display("FAIL IF_ID_Write vec %0d got %b exp %b", vectors, IF_ID_Write, e.ifw); end
            if (IF_ID_Flush !== e.fl) begin miscompares++;
               $display("FAIL IF_ID_Flush vec %0d got %b exp %b", vectors, IF_ID_Flush, e.fl); end
            if (ID_EX_Bubble !== e.bub) begin miscompares++;
               $display("FAIL ID_EX_Bubble vec %0d got %b exp %b", vectors, ID_EX_Bubble, e.bub); end
            if (mdu_busy !== e.busy) begin miscompares++;
               $display("FAIL mdu_busy vec %0d got %b exp %b", vectors, mdu_busy, e.busy); end
            if (mdu_done !== e.done) begin miscompares++;
               $display("FAIL mdu_done vec %0d got %b exp %b", vectors, mdu_done, e.done); end
            if (stall_cycles !== e.sc) begin miscompares++;
               $display("FAIL stall_cycles vec %0d got %0d exp %0d", vectors, stall_cycles, e.sc); end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout vectors %0d exp 0 pending", vectors);
      $fatal(1, "timeout");
   end

   initial begin
      int wait_cnt;
      rst_n = 0; MemRead_ID_EX = 0; rt_ID_EX = 0; rs_IF_ID = 0; rt_IF_ID = 0;
      uses_rt_IF_ID = 0; mdu_start_ID = 0; hilo_read_ID = 0; jump_ID = 0; branch_taken_EX = 0;
      // reset state
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 1, 5, 5, 0, 0, 1, 0, 0, 0);
      idle(2);
      // T1 load-use on rs
      step(1, 1, 5, 5, 0, 0, 0, 0, 0, 0);
      idle(2);
      // T2 $0 destination, rt match without uses_rt, rt match with uses_rt
      step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
      step(1, 1, 7, 3, 7, 0, 0, 0, 0, 0);
      step(1, 1, 7, 3, 7, 1, 0, 0, 0, 0);
      idle(1);
      // T3 mult then mflo held in ID while busy
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < LAT + 1; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      idle(2);
      // flushed mult is not accepted
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      idle(2);
      // T4 load-use with taken branch
      step(1, 1, 9, 9, 0, 0, 0, 0, 0, 1);
      // T5 jump during load-use, then jump leaves ID
      step(1, 1, 4, 0, 4, 1, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      idle(1);
      // T6 reset mid-RUN, no done pulse afterwards
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      idle(3);
      // saturation of the stall counter
      for (int i = 0; i < CMAX + 3; i++) step(1, 1, 6, 6, 0, 0, 0, 0, 0, 0);
      idle(2);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic with a small register pool so matches are frequent
      for (int i = 0; i < 3000; i++) begin
         step(($urandom_range(199) != 0), ($urandom_range(2) == 0),
              int'($urandom_range(3)), int'($urandom_range(3)), int'($urandom_range(3)),
              $urandom_range(1) == 1, ($urandom_range(3) == 0), ($urandom_range(3) == 0),
              ($urandom_range(5) == 0), ($urandom_range(7) == 0));
      end
      wait_cnt = 0;
      while (exp_q.size() > 0 && wait_cnt < 20) begin
         @(negedge clk);
         wait_cnt++;
      end
      #5;
      if (exp_q.size() > 0) begin
         miscompares++;
         $display("FAIL drain pending %0d exp 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
